// File: rtl/muldiv_pkg.sv
// Shared encodings for the Hi/Lo multiply-divide unit.
// Op codes and FSM state constants used by hilo_muldiv and muldiv_step.
package muldiv_pkg;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative unsigned multiply / restoring divide.
// Divide datapath exists only when HILO_MULDIV_DIVIDE_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH:0] sum;
`ifdef HILO_MULDIV_DIVIDE_EN
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;
`endif

  always_comb begin
    // multiply: add, then shift {acc,q} right one bit
    sum   = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
    acc_n = sum[WIDTH:1];
    q_n   = {sum[0], q[WIDTH-1:1]};
`ifdef HILO_MULDIV_DIVIDE_EN
    rem  = {acc, q[WIDTH-1]};
    diff = rem - {1'b0, b};
    if (op == OP_DIVU) begin
      if (rem >= {1'b0, b}) begin
        acc_n = diff[WIDTH-1:0];
        q_n   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = rem[WIDTH-1:0];
        q_n   = {q[WIDTH-2:0], 1'b0};
      end
    end
`else
    if (op == OP_DIVU) begin
      acc_n = acc;
      q_n   = q;
    end
`endif
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULTU/DIVU unit writing a Hi/Lo pair, WIDTH steps per op.
// Define HILO_MULDIV_DIVIDE_EN to build in the unsigned divider.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             op_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] q_n;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op   (op_r),
    .acc  (acc),
    .q    (q),
    .b    (b),
    .acc_n(acc_n),
    .q_n  (q_n)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_r  <= OP_MULTU;
      acc   <= '0;
      q     <= '0;
      b     <= '0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) begin
`ifndef HILO_MULDIV_DIVIDE_EN
            // no divider: DIVU completes at once with a zero result
            if (Op == OP_DIVU) begin
              state <= S_DONE;
              Hi    <= '0;
              Lo    <= '0;
            end else
`endif
            begin
              state <= S_RUN;
              op_r  <= Op;
              acc   <= '0;
              q     <= DataA;
              b     <= DataB;
              cnt   <= '0;
            end
          end
        end
        S_RUN: begin
          acc <= acc_n;
          q   <= q_n;
          if (cnt == LAST) begin
            state <= S_DONE;
            cnt   <= '0;
            Hi    <= acc_n;
            Lo    <= q_n;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (state == S_RUN);
  assign Done = (state == S_DONE);

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized bench for hilo_muldiv against a transaction-level model.
// Follows HILO_MULDIV_DIVIDE_EN to pick the expected DIVU behaviour.
module tb_hilo_muldiv;

  localparam int W = 32;
`ifdef HILO_MULDIV_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic         Op = 1'b0;
  logic [W-1:0] DataA = '0;
  logic [W-1:0] DataB = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .Start(Start),
    .Op   (Op),
    .DataA(DataA),
    .DataB(DataB),
    .Busy (Busy),
    .Done (Done),
    .Hi   (Hi),
    .Lo   (Lo)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // architectural result of one operation
  function automatic void calc(input logic op, input logic [W-1:0] a,
                               input logic [W-1:0] bb,
                               output logic [W-1:0] hi,
                               output logic [W-1:0] lo);
    logic [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(bb);
    hi = p[2*W-1:W];
    lo = p[W-1:0];
    if (op) begin
      hi = '0;
      lo = '0;
      if (DIV_EN) begin
        if (bb == 0) begin
          lo = '1;
          hi = a;
        end else begin
          lo = a / bb;
          hi = a % bb;
        end
      end
    end
  endfunction

  // timeline model: an accepted op finishes W edges later (or at once
  // for DIVU without a divider), then one idle edge ignores Start
  int           edge_n = 0;
  int           done_edge = 0;
  bit           active = 1'b0;
  bit           chk_en = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] p_hi = '0;
  logic [W-1:0] p_lo = '0;

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      active = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      m_done = 1'b0;
      if (!active) begin
        if (Start) begin
          active = 1'b1;
          calc(Op, DataA, DataB, p_hi, p_lo);
          if (!Op || DIV_EN) begin
            done_edge = edge_n + W;
            m_busy = 1'b1;
          end else begin
            done_edge = edge_n;
          end
        end
      end else if (edge_n == done_edge + 1) begin
        active = 1'b0;
      end
      if (active && edge_n == done_edge) begin
        m_hi   = p_hi;
        m_lo   = p_lo;
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(Busy), 64'(m_busy));
      chk("done", 64'(Done), 64'(m_done));
      chk("hi", 64'(Hi), 64'(m_hi));
      chk("lo", 64'(Lo), 64'(m_lo));
    end
  end

  // issue one op; optionally re-pulse Start with new DataA at cycle poke
  task automatic go(input logic op, input logic [W-1:0] a,
                    input logic [W-1:0] bb, input int poke,
                    output int lat, output logic [W-1:0] hi,
                    output logic [W-1:0] lo);
    @(negedge clk);
    Start = 1'b1;
    Op    = op;
    DataA = a;
    DataB = bb;
    lat   = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      Start = 1'b0;
      if (Done) break;
      if (poke != 0 && lat == poke) begin
        Start = 1'b1;
        DataA = ~a;
      end
      if (lat >= 200) begin
        chk("done_timeout", 64'(lat), 64'(W + 1));
        break;
      end
    end
    hi = Hi;
    lo = Lo;
  endtask

  int           lat;
  int           nd;
  int           t0;
  int           tq[$];
  logic [W-1:0] rh;
  logic [W-1:0] rl;
  logic [W-1:0] eh;
  logic [W-1:0] el;
  logic         rop;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    rst_n = 1'b1;

    go(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, rh, rl);
    chk("mul_max", {rh, rl}, 64'hFFFFFFFE_00000001);
    chk("mul_lat", 64'(lat), 64'd33);
    chk("model_pin", {m_hi, m_lo}, 64'hFFFFFFFE_00000001);

    go(1'b1, 32'd100, 32'd7, 0, lat, rh, rl);
    if (DIV_EN) begin
      chk("div_100_7", {rh, rl}, {32'd2, 32'd14});
      chk("div_lat", 64'(lat), 64'd33);
    end else begin
      chk("nodiv_res", {rh, rl}, 64'd0);
      chk("nodiv_lat", 64'(lat), 64'd1);
    end
    go(1'b1, 32'd5, 32'd0, 0, lat, rh, rl);
    if (DIV_EN) chk("div_by0", {rh, rl}, {32'd5, 32'hFFFFFFFF});
    else chk("nodiv_by0", {rh, rl}, 64'd0);

    go(1'b0, 32'd6, 32'd7, 5, lat, rh, rl);
    chk("busy_poke", {rh, rl}, 64'd42);
    chk("poke_lat", 64'(lat), 64'd33);

    // reset mid-run, asserted together with Start
    @(negedge clk);
    Start = 1'b1;
    Op    = 1'b0;
    DataA = 32'd1234;
    DataB = 32'd5678;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    Start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    Start = 1'b0;
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    chk("mid_rst_hilo", {Hi, Lo}, 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) nd++;
    end
    chk("mid_rst_nodone", 64'(nd), 64'd0);
    go(1'b0, 32'd3, 32'd4, 0, lat, rh, rl);
    chk("mul_3_4", {rh, rl}, 64'd12);

    // back-to-back with Start held high
    @(negedge clk);
    Start = 1'b1;
    Op    = 1'b0;
    t0    = 0;
    while (tq.size() < 4 && t0 < 300) begin
      DataA = $urandom;
      DataB = $urandom;
      @(negedge clk);
      t0++;
      if (Done) tq.push_back(t0);
    end
    Start = 1'b0;
    if (tq.size() < 4) chk("b2b_timeout", 64'(tq.size()), 64'd4);
    else for (int i = 1; i < 4; i++)
      chk("b2b_gap", 64'(tq[i] - tq[i-1]), 64'd34);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      rop = 1'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = '0;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 255));
      if ($urandom_range(0, 4) == 0) ra = 32'($urandom_range(0, 1000));
      calc(rop, ra, rb, eh, el);
      go(rop, ra, rb, int'($urandom_range(0, 30)), lat, rh, rl);
      chk("rand_res", {rh, rl}, {eh, el});
      chk("rand_lat", 64'(lat), (!rop || DIV_EN) ? 64'd33 : 64'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
